// File: rtl/axil_master.sv
// ---------------------------------------------------------------------------
// axil_master
//   Single-outstanding AXI4-Lite master. A simple valid/ready command port
//   launches one read or write. The result comes back as a one-cycle response
//   strobe carrying the read data (0 for writes) and the AXI response code.
//
// Optional feature (compile-time macro):
//   AXIL_MST_TIMEOUT_EN - abort any transaction that stays outside IDLE for
//                         TIMEOUT_CYCLES cycles. The abort reports SLVERR
//                         (2'b10) and sets a sticky to_timeout flag. Without
//                         the macro the master waits forever and to_timeout
//                         is tied low.
//
// Ports:
//   iclk, irst            clock, asynchronous active-high reset
//   from_cmd_*/to_cmd_*   command request (valid/ready, wr, addr, wdata)
//   to_rsp_*              response strobe, read data, resp code
//   to_timeout            sticky abort flag
//   to_aw*/to_w*/..b*     AXI4-Lite write address, data and response channels
//   to_ar*/..r*           AXI4-Lite read address and data channels
//
// State table:
//   state       | meaning
//   ST_IDLE     | waiting for a command, to_cmd_ready high
//   ST_WR       | AW and/or W handshake still outstanding
//   ST_WR_RESP  | both write handshakes done, waiting for B
//   ST_RD_ADDR  | AR valid, waiting for arready
//   ST_RD_DATA  | waiting for R
// ---------------------------------------------------------------------------
module axil_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    iclk,
    input  logic                    irst,
    input  logic                    from_cmd_valid,
    output logic                    to_cmd_ready,
    input  logic                    from_cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   from_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   from_cmd_wdata,
    output logic                    to_rsp_valid,
    output logic [DATA_WIDTH-1:0]   to_rsp_rdata,
    output logic [1:0]              to_rsp_resp,
    output logic                    to_timeout,
    output logic [ADDR_WIDTH-1:0]   to_awaddr,
    output logic                    to_awvalid,
    input  logic                    from_awready,
    output logic [DATA_WIDTH-1:0]   to_wdata,
    output logic [DATA_WIDTH/8-1:0] to_wstrb,
    output logic                    to_wvalid,
    input  logic                    from_wready,
    input  logic [1:0]              from_bresp,
    input  logic                    from_bvalid,
    output logic                    to_bready,
    output logic [ADDR_WIDTH-1:0]   to_araddr,
    output logic                    to_arvalid,
    input  logic                    from_arready,
    input  logic [DATA_WIDTH-1:0]   from_rdata,
    input  logic [1:0]              from_rresp,
    input  logic                    from_rvalid,
    output logic                    to_rready
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Held low while in reset and set on the first edge after release, so
    // to_cmd_ready stays 0 during reset even though the state is IDLE.
    logic                  r_rdy_en;
    logic                  r_aw_pend;
    logic                  r_w_pend;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_resp;

    logic                  w_accept;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_r_hs;

    assign w_accept = (r_state == ST_IDLE) && r_rdy_en && from_cmd_valid;
    assign w_aw_hs  = (r_state == ST_WR) && r_aw_pend && from_awready;
    assign w_w_hs   = (r_state == ST_WR) && r_w_pend && from_wready;
    // B and R are only honoured in their own states; strays elsewhere are ignored.
    assign w_b_hs   = (r_state == ST_WR_RESP) && from_bvalid;
    assign w_r_hs   = (r_state == ST_RD_DATA) && from_rvalid;

`ifdef AXIL_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_abort;

    // r_cnt is 0 in IDLE, so on the Nth cycle outside IDLE it reads N-1.
    // A genuine completion on the same cycle wins over the abort.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_abort    = (r_state != ST_IDLE) &&
                        (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                        !(w_b_hs || w_r_hs);
    assign to_timeout = r_timeout;
`else
    assign to_timeout = 1'b0;

    // TIMEOUT_CYCLES only matters when the abort timer is built in.
    if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        to_cmd_ready = 1'b0;
        to_awvalid   = 1'b0;
        to_wvalid    = 1'b0;
        to_bready    = 1'b0;
        to_arvalid   = 1'b0;
        to_rready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                to_cmd_ready = r_rdy_en;
                if (w_accept) begin
                    w_state_nxt = from_cmd_wr ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                to_awvalid = r_aw_pend;
                to_wvalid  = r_w_pend;
                if ((!r_aw_pend || from_awready) && (!r_w_pend || from_wready)) begin
                    w_state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                to_bready = 1'b1;
                if (from_bvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                to_arvalid = 1'b1;
                if (from_arready) begin
                    w_state_nxt = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                to_rready = 1'b1;
                if (from_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
`ifdef AXIL_MST_TIMEOUT_EN
        // Valids/readies are state-derived, so they fall on the next cycle.
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_rdy_en    <= 1'b0;
            r_aw_pend   <= 1'b0;
            r_w_pend    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_resp      <= 2'b00;
`ifdef AXIL_MST_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_rdy_en    <= 1'b1;
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_addr    <= from_cmd_addr;
                r_wdata   <= from_cmd_wdata;
                r_aw_pend <= from_cmd_wr;
                r_w_pend  <= from_cmd_wr;
            end
            if (w_aw_hs) begin
                r_aw_pend <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_pend <= 1'b0;
            end
            if (w_b_hs) begin
                r_rsp_valid <= 1'b1;
                r_resp      <= from_bresp;
                r_rdata     <= '0;
            end
            if (w_r_hs) begin
                r_rsp_valid <= 1'b1;
                r_resp      <= from_rresp;
                r_rdata     <= from_rdata;
            end
`ifdef AXIL_MST_TIMEOUT_EN
            if (w_abort) begin
                r_rsp_valid <= 1'b1;
                r_resp      <= 2'b10;
                r_rdata     <= '0;
                r_timeout   <= 1'b1;
                r_aw_pend   <= 1'b0;
                r_w_pend    <= 1'b0;
            end
`endif
        end
    end

    assign to_awaddr    = r_addr;
    assign to_araddr    = r_addr;
    assign to_wdata     = r_wdata;
    assign to_wstrb     = '1;
    assign to_rsp_valid = r_rsp_valid;
    assign to_rsp_rdata = r_rdata;
    assign to_rsp_resp  = r_resp;

endmodule

// File: tb/tb_axil_master.sv
// ---------------------------------------------------------------------------
// tb_axil_master
//   Self-checking bench for axil_master. A per-transaction reference schedule
//   is derived from the slave's chosen ready/valid delays: the cycle each
//   channel handshakes and the cycle the response strobe must appear. Every
//   cycle of the transaction is then compared against that schedule.
// ---------------------------------------------------------------------------
module tb_axil_master;

    logic        iclk = 1'b0;
    logic        irst;
    logic        from_cmd_valid;
    logic        to_cmd_ready;
    logic        from_cmd_wr;
    logic [15:0] from_cmd_addr;
    logic [15:0] from_cmd_wdata;
    logic        to_rsp_valid;
    logic [15:0] to_rsp_rdata;
    logic [1:0]  to_rsp_resp;
    logic        to_timeout;
    logic [15:0] to_awaddr;
    logic        to_awvalid;
    logic        from_awready;
    logic [15:0] to_wdata;
    logic [1:0]  to_wstrb;
    logic        to_wvalid;
    logic        from_wready;
    logic [1:0]  from_bresp;
    logic        from_bvalid;
    logic        to_bready;
    logic [15:0] to_araddr;
    logic        to_arvalid;
    logic        from_arready;
    logic [15:0] from_rdata;
    logic [1:0]  from_rresp;
    logic        from_rvalid;
    logic        to_rready;

    int n_checks = 0;
    int n_errors = 0;

    axil_master #(
        .ADDR_WIDTH     (16),
        .DATA_WIDTH     (16),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .iclk           (iclk),
        .irst           (irst),
        .from_cmd_valid (from_cmd_valid),
        .to_cmd_ready   (to_cmd_ready),
        .from_cmd_wr    (from_cmd_wr),
        .from_cmd_addr  (from_cmd_addr),
        .from_cmd_wdata (from_cmd_wdata),
        .to_rsp_valid   (to_rsp_valid),
        .to_rsp_rdata   (to_rsp_rdata),
        .to_rsp_resp    (to_rsp_resp),
        .to_timeout     (to_timeout),
        .to_awaddr      (to_awaddr),
        .to_awvalid     (to_awvalid),
        .from_awready   (from_awready),
        .to_wdata       (to_wdata),
        .to_wstrb       (to_wstrb),
        .to_wvalid      (to_wvalid),
        .from_wready    (from_wready),
        .from_bresp     (from_bresp),
        .from_bvalid    (from_bvalid),
        .to_bready      (to_bready),
        .to_araddr      (to_araddr),
        .to_arvalid     (to_arvalid),
        .from_arready   (from_arready),
        .from_rdata     (from_rdata),
        .from_rresp     (from_rresp),
        .from_rvalid    (from_rvalid),
        .to_rready      (to_rready)
    );

    always #5 iclk = ~iclk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_val({tag, "_cmd_ready"}, 32'(to_cmd_ready), 32'd0);
        chk_val({tag, "_awvalid"},   32'(to_awvalid),   32'd0);
        chk_val({tag, "_wvalid"},    32'(to_wvalid),    32'd0);
        chk_val({tag, "_bready"},    32'(to_bready),    32'd0);
        chk_val({tag, "_arvalid"},   32'(to_arvalid),   32'd0);
        chk_val({tag, "_rready"},    32'(to_rready),    32'd0);
        chk_val({tag, "_rsp_valid"}, 32'(to_rsp_valid), 32'd0);
        chk_val({tag, "_awaddr"},    32'(to_awaddr),    32'd0);
        chk_val({tag, "_araddr"},    32'(to_araddr),    32'd0);
        chk_val({tag, "_wdata"},     32'(to_wdata),     32'd0);
        chk_val({tag, "_rsp_rdata"}, 32'(to_rsp_rdata), 32'd0);
        chk_val({tag, "_rsp_resp"},  32'(to_rsp_resp),  32'd0);
        chk_val({tag, "_timeout"},   32'(to_timeout),   32'd0);
    endtask

    // Called one step after an edge with the master in IDLE. Returns on the
    // cycle the response strobe is (expected to be) high, so a following call
    // issues its command on exactly that cycle.
    //   d_a : cycles AW/AR valid waits before ready
    //   d_w : cycles W valid waits before ready (writes)
    //   d_b : cycles B/R ready waits before valid
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input int d_a, input int d_w, input int d_b,
                           input logic [1:0] resp, input logic [15:0] rdata);
        int a_cyc, w_cyc, b0, bh, lat;
        // Reference schedule, cycle 0 = accept.
        a_cyc = 1 + d_a;
        w_cyc = wr ? 1 + d_w : 0;
        b0    = (wr ? ((a_cyc > w_cyc) ? a_cyc : w_cyc) : a_cyc) + 1;
        bh    = b0 + d_b;
        lat   = bh + 1;

        from_cmd_valid = 1'b1;
        from_cmd_wr    = wr;
        from_cmd_addr  = addr;
        from_cmd_wdata = wdata;
        chk_val("accept_ready", 32'(to_cmd_ready), 32'd1);
        tick();
        from_cmd_valid = 1'b0;
        from_cmd_wr    = 1'($urandom);
        from_cmd_addr  = 16'($urandom);
        from_cmd_wdata = 16'($urandom);

        for (int cyc = 1; cyc <= lat; cyc++) begin
            if (wr) begin
                from_awready = (cyc >= a_cyc);
                from_wready  = (cyc >= w_cyc);
                from_bvalid  = (cyc >= bh) || (cyc < b0 && $urandom_range(0, 1) == 1);
                from_bresp   = (cyc >= bh) ? resp : 2'($urandom);
                from_arready = 1'($urandom);
                from_rvalid  = 1'($urandom);
                from_rdata   = 16'($urandom);
                from_rresp   = 2'($urandom);
            end else begin
                from_arready = (cyc >= a_cyc);
                from_rvalid  = (cyc >= bh) || (cyc < b0 && $urandom_range(0, 1) == 1);
                from_rdata   = (cyc >= bh) ? rdata : 16'($urandom);
                from_rresp   = (cyc >= bh) ? resp : 2'($urandom);
                from_awready = 1'($urandom);
                from_wready  = 1'($urandom);
                from_bvalid  = 1'($urandom);
                from_bresp   = 2'($urandom);
            end
            chk_val("cmd_ready", 32'(to_cmd_ready), 32'(cyc == lat));
            chk_val("rsp_valid", 32'(to_rsp_valid), 32'(cyc == lat));
            chk_val("awvalid",   32'(to_awvalid),   32'(wr && cyc <= a_cyc));
            chk_val("wvalid",    32'(to_wvalid),    32'(wr && cyc <= w_cyc));
            chk_val("bready",    32'(to_bready),    32'(wr && cyc >= b0 && cyc <= bh));
            chk_val("arvalid",   32'(to_arvalid),   32'(!wr && cyc <= a_cyc));
            chk_val("rready",    32'(to_rready),    32'(!wr && cyc >= b0 && cyc <= bh));
            if (wr && cyc <= a_cyc) begin
                chk_val("awaddr", 32'(to_awaddr), 32'(addr));
            end
            if (wr && cyc <= w_cyc) begin
                chk_val("wdata", 32'(to_wdata), 32'(wdata));
                chk_val("wstrb", 32'(to_wstrb), 32'h3);
            end
            if (!wr && cyc <= a_cyc) begin
                chk_val("araddr", 32'(to_araddr), 32'(addr));
            end
            if (cyc == lat) begin
                chk_val("rsp_resp",  32'(to_rsp_resp),  32'(resp));
                chk_val("rsp_rdata", 32'(to_rsp_rdata), wr ? 32'd0 : 32'(rdata));
            end
            if (cyc < lat) begin
                tick();
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        from_cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk_val("idle_ready", 32'(to_cmd_ready), 32'd1);
            chk_val("idle_rsp",   32'(to_rsp_valid), 32'd0);
        end
    endtask

    initial begin
        irst           = 1'b1;
        from_cmd_valid = 1'b0;
        from_cmd_wr    = 1'b0;
        from_cmd_addr  = '0;
        from_cmd_wdata = '0;
        from_awready   = 1'b0;
        from_wready    = 1'b0;
        from_bresp     = 2'b00;
        from_bvalid    = 1'b0;
        from_arready   = 1'b0;
        from_rdata     = '0;
        from_rresp     = 2'b00;
        from_rvalid    = 1'b0;

        repeat (3) @(posedge iclk);
        #1;
        chk_reset_outputs("por");
        #2 irst = 1'b0;
        #1;
        chk_val("ready_before_first_edge", 32'(to_cmd_ready), 32'd0);
        tick();
        chk_val("ready_after_release", 32'(to_cmd_ready), 32'd1);

        // Directed cases.
        run_txn(1'b1, 16'h1004, 16'h00AB, 0, 0, 0, 2'b00, 16'h0000);
        run_txn(1'b1, 16'h1004, 16'h00AB, 0, 3, 0, 2'b00, 16'h0000);
        run_txn(1'b0, 16'h3002, 16'h0000, 2, 0, 0, 2'b00, 16'h5A5A);
        run_txn(1'b1, 16'h0040, 16'h1234, 1, 0, 1, 2'b10, 16'h0000);
        run_txn(1'b0, 16'h0042, 16'h0000, 0, 0, 2, 2'b01, 16'hBEEF);
        run_txn(1'b1, 16'h0044, 16'h4321, 2, 0, 0, 2'b11, 16'h0000);
        idle_cycles(2);

        // Reset while waiting for B.
        from_bvalid    = 1'b0;
        from_rvalid    = 1'b0;
        from_awready   = 1'b1;
        from_wready    = 1'b1;
        from_cmd_valid = 1'b1;
        from_cmd_wr    = 1'b1;
        from_cmd_addr  = 16'h2222;
        from_cmd_wdata = 16'h1111;
        tick();
        from_cmd_valid = 1'b0;
        tick();
        chk_val("wr_resp_bready", 32'(to_bready), 32'd1);
        irst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        tick();
        chk_reset_outputs("rst_hold");
        #2 irst = 1'b0;
        #1;
        chk_val("rst_mid_ready_pre", 32'(to_cmd_ready), 32'd0);
        tick();
        chk_val("rst_mid_ready_post", 32'(to_cmd_ready), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            logic       wr;
            logic [1:0] resp;
            wr   = 1'($urandom);
            resp = 2'($urandom);
            run_txn(wr, 16'($urandom), 16'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                    resp, 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                idle_cycles($urandom_range(1, 3));
            end
        end

`ifdef AXIL_MST_TIMEOUT_EN
        begin
            int got;
            got            = -1;
            from_arready   = 1'b0;
            from_rvalid    = 1'b0;
            from_cmd_valid = 1'b1;
            from_cmd_wr    = 1'b0;
            from_cmd_addr  = 16'h0BAD;
            tick();
            from_cmd_valid = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                if (to_rsp_valid) begin
                    got = c;
                    break;
                end
                chk_val("to_arvalid_held", 32'(to_arvalid), 32'd1);
                tick();
            end
            chk_val("to_rsp_cycle", 32'(got), 32'd17);
            chk_val("to_rsp_resp",  32'(to_rsp_resp), 32'h2);
            chk_val("to_flag",      32'(to_timeout),  32'd1);
            chk_val("to_arvalid",   32'(to_arvalid),  32'd0);
            tick();
            chk_val("to_flag_sticky", 32'(to_timeout), 32'd1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
